// File: rtl/game_timer_ctrl.sv
// Countdown timer for the GAME state: whole-second countdown with pause, bonus top-up,
// a low-time warning and a single end_of_time pulse back to the game FSM.
module game_timer_ctrl #(
  parameter int         CLK_FREQ_HZ = 100_000_000,
  parameter int         GAME_TIME   = 30,
  parameter int         BONUS_TIME  = 5,
  parameter int         WARN_TIME   = 5,
  parameter int         SEC_W       = 8,
  parameter logic [1:0] GAME_STATE  = 2'b10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       state_in,
  input  logic             pause,
  input  logic             add_time,
  output logic             end_of_time,
  output logic [SEC_W-1:0] seconds_left,
  output logic             warning,
  output logic             running
);

  localparam int               PW        = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(CLK_FREQ_HZ - 1);
  localparam logic [SEC_W:0]   SEC_SAT   = {1'b0, {SEC_W{1'b1}}};
  localparam logic [SEC_W-1:0] SEC_INIT  = SEC_W'(GAME_TIME);
  localparam logic [SEC_W:0]   BONUS     = (SEC_W+1)'(BONUS_TIME);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_EXPIRED
  } state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    presc, presc_nxt;
  logic [SEC_W-1:0] sec_nxt, sec_sat;
  logic [SEC_W:0]   sec_sum;
  logic             in_game, tick, warn_nxt;

  assign in_game = (state_in == GAME_STATE);
  assign tick    = (state == S_RUN) && (presc == PRESC_MAX);

  // One extra bit of headroom lets the bonus overflow be detected and clamped.
  always_comb begin
    sec_sum = {1'b0, seconds_left} - {{SEC_W{1'b0}}, tick} + (add_time ? BONUS : '0);
    sec_sat = (sec_sum > SEC_SAT) ? SEC_SAT[SEC_W-1:0] : sec_sum[SEC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Leaving GAME always wins, then expiry, then pause handling.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    sec_nxt   = seconds_left;
    case (state)
      S_IDLE: begin
        presc_nxt = '0;
        sec_nxt   = SEC_INIT;
        if (in_game) state_nxt = pause ? S_PAUSE : S_RUN;
      end
      S_RUN: begin
        presc_nxt = tick ? '0 : presc + 1'b1;
        sec_nxt   = sec_sat;
        if (!in_game) begin
          state_nxt = S_IDLE;
          presc_nxt = '0;
          sec_nxt   = SEC_INIT;
        end else if (sec_sat == '0) begin
          state_nxt = S_EXPIRED;
        end else if (pause) begin
          state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        sec_nxt = sec_sat;
        if (!in_game) begin
          state_nxt = S_IDLE;
          presc_nxt = '0;
          sec_nxt   = SEC_INIT;
        end else if (!pause) begin
          state_nxt = S_RUN;
        end
      end
      S_EXPIRED: begin
        presc_nxt = '0;
        sec_nxt   = '0;
        if (!in_game) begin
          state_nxt = S_IDLE;
          sec_nxt   = SEC_INIT;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        presc_nxt = '0;
        sec_nxt   = SEC_INIT;
      end
    endcase
  end

  assign warn_nxt = ((state_nxt == S_RUN) || (state_nxt == S_PAUSE)) &&
                    (sec_nxt != '0) && (int'(sec_nxt) <= WARN_TIME);

  // Flags are computed from next-state values so they line up with seconds_left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= '0;
      seconds_left <= SEC_INIT;
      end_of_time  <= 1'b0;
      warning      <= 1'b0;
      running      <= 1'b0;
    end else begin
      presc        <= presc_nxt;
      seconds_left <= sec_nxt;
      end_of_time  <= (state == S_RUN) && (state_nxt == S_EXPIRED);
      warning      <= warn_nxt;
      running      <= (state_nxt == S_RUN);
    end
  end

endmodule
